// File: rtl/ahb2apb_bridge_if.sv
// rtl/ahb2apb_bridge_if.sv - AHB-Lite slave side and APB master side signals of the bridge
interface ahb2apb_bridge_if;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        pwrite;
  logic        penable;
  logic [2:0]  pselx;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  // slave: the bridge's view; master: the AHB master plus APB fabric around it
  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata, prdata,
    output pwrite, penable, pselx, paddr, pwdata, hreadyout, hresp, hrdata
  );

  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata, prdata,
    input  pwrite, penable, pselx, paddr, pwdata, hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// rtl/ahb2apb_bridge.sv - AHB-Lite slave to APB master bridge replaying transfers as SETUP/ENABLE
module ahb2apb_bridge (
  input  logic            hclk,
  input  logic            hresetn,
  ahb2apb_bridge_if.slave bus,
  output logic [2:0]      ps,
  output logic [2:0]      ns
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WWAIT    = 3'd1,
    ST_READ     = 3'd2,
    ST_WRITE    = 3'd3,
    ST_WRITEP   = 3'd4,
    ST_RENABLE  = 3'd5,
    ST_WENABLE  = 3'd6,
    ST_WENABLEP = 3'd7
  } state_t;

  state_t      ps_q, ns_d;
  logic [31:0] hadd1_q, hadd1_d, hadd2_q, hadd2_d, hdata1_q, hdata1_d;
  logic        hwrite_reg_q, hwrite_reg_d;
  logic [31:0] paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic        pwrite_q, pwrite_d, penable_q, penable_d;
  logic        hreadyout_q, hreadyout_d;
  logic [2:0]  pselx_q, pselx_d;
  logic [2:0]  tempselx;
  logic        in_map, valid, rd_req, wr_req;

  assign in_map = (bus.haddr >= 32'h8000_0000) && (bus.haddr <= 32'h8BFF_FFFF);
  assign valid  = bus.hreadyin && ((bus.htrans == 2'b10) || (bus.htrans == 2'b11)) && in_map;
  assign rd_req = valid && !bus.hwrite;
  assign wr_req = valid && bus.hwrite;

  // Inside the map the top nibble is fixed, so bits 27:26 pick the 64 MB slave window
  always_comb begin
    tempselx = 3'b000;
    if (in_map) begin
      case (bus.haddr[27:26])
        2'b00:   tempselx = 3'b001;
        2'b01:   tempselx = 3'b010;
        2'b10:   tempselx = 3'b100;
        default: tempselx = 3'b000;
      endcase
    end
  end

  always_comb begin
    hadd1_d      = bus.haddr;
    hadd2_d      = hadd1_q;
    hdata1_d     = bus.hwdata;
    hwrite_reg_d = bus.hwrite;

    ns_d = ps_q;
    case (ps_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE:
        ns_d = rd_req ? ST_READ : (wr_req ? ST_WWAIT : ST_IDLE);
      ST_WWAIT:    ns_d = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     ns_d = ST_RENABLE;
      ST_WRITEP:   ns_d = ST_WENABLEP;
      ST_WRITE:    ns_d = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WENABLEP: ns_d = !hwrite_reg_q ? ST_READ : (valid ? ST_WRITEP : ST_WRITE);
      default:     ns_d = ST_IDLE;
    endcase
  end

  // Outputs are precomputed for the state being entered, so they line up with ps after the edge
  always_comb begin
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    penable_d   = penable_q;
    hreadyout_d = hreadyout_q;
    pselx_d     = pselx_q;
    case (ps_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        penable_d = 1'b0;
        if (rd_req) begin
          paddr_d     = bus.haddr;
          pwrite_d    = 1'b0;
          pselx_d     = tempselx;
          hreadyout_d = 1'b0;
        end else begin
          pselx_d     = 3'b000;
          hreadyout_d = 1'b1;
        end
      end
      ST_WWAIT: begin
        paddr_d     = hadd1_q;
        pwdata_d    = bus.hwdata;
        pwrite_d    = 1'b1;
        pselx_d     = tempselx;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
      end
      ST_READ, ST_WRITE, ST_WRITEP: begin
        penable_d   = 1'b1;
        hreadyout_d = 1'b1;
      end
      ST_WENABLEP: begin
        // Pipelined burst: the address two beats back pairs with the data one beat back
        paddr_d     = hadd2_q;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
        if (hwrite_reg_q) begin
          pwdata_d = hdata1_q;
          pwrite_d = 1'b1;
        end else begin
          pwrite_d = 1'b0;
        end
      end
      default: begin
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ps_q         <= ST_IDLE;
      hadd1_q      <= '0;
      hadd2_q      <= '0;
      hdata1_q     <= '0;
      hwrite_reg_q <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      penable_q    <= 1'b0;
      hreadyout_q  <= 1'b1;
      pselx_q      <= 3'b000;
    end else begin
      ps_q         <= ns_d;
      hadd1_q      <= hadd1_d;
      hadd2_q      <= hadd2_d;
      hdata1_q     <= hdata1_d;
      hwrite_reg_q <= hwrite_reg_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      penable_q    <= penable_d;
      hreadyout_q  <= hreadyout_d;
      pselx_q      <= pselx_d;
    end
  end

  assign ps            = ps_q;
  assign ns            = ns_d;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.penable   = penable_q;
  assign bus.pselx     = pselx_q;
  assign bus.hreadyout = hreadyout_q;
  assign bus.hresp     = 2'b00;
  assign bus.hrdata    = bus.prdata;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb/tb_ahb2apb_bridge.sv - directed self-checking bench for ahb2apb_bridge
module tb_ahb2apb_bridge;
  logic       hclk;
  logic       hresetn;
  logic [2:0] ps;
  logic [2:0] ns;
  int         n_assert;
  int         n_fail;

  ahb2apb_bridge_if bus ();

  ahb2apb_bridge dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus),
    .ps     (ps),
    .ns     (ns)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w,
                       input logic [31:0] d);
    bus.haddr  = a;
    bus.htrans = t;
    bus.hwrite = w;
    bus.hwdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    hresetn      = 1'b0;
    bus.hreadyin = 1'b1;
    bus.prdata   = 32'h0;
    drive(32'h0, 2'b00, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_ps", ps, 0);
    chk("rst_pselx", bus.pselx, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_hreadyout", bus.hreadyout, 1);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_hresp", bus.hresp, 0);
    hresetn = 1'b1;
    tick();

    // single write 0x8000_0000 / 0x1234
    drive(32'h8000_0000, 2'b10, 1'b1, 32'h0);
    #1 chk("sw_ns_idle", ns, 1);
    tick();
    chk("sw_ps_wwait", ps, 1);
    chk("sw_hrdy_wwait", bus.hreadyout, 1);
    chk("sw_psel_wwait", bus.pselx, 0);
    drive(32'h8000_0000, 2'b00, 1'b1, 32'h0000_1234);
    #1 chk("sw_ns_wwait", ns, 3);
    tick();
    chk("sw_ps_write", ps, 3);
    chk("sw_pselx", bus.pselx, 3'b001);
    chk("sw_pwrite", bus.pwrite, 1);
    chk("sw_paddr", bus.paddr, 32'h8000_0000);
    chk("sw_pwdata", bus.pwdata, 32'h0000_1234);
    chk("sw_penable0", bus.penable, 0);
    chk("sw_hrdy_write", bus.hreadyout, 0);
    tick();
    chk("sw_ps_wenable", ps, 6);
    chk("sw_penable1", bus.penable, 1);
    chk("sw_hrdy_wen", bus.hreadyout, 1);
    tick();
    chk("sw_ps_idle", ps, 0);
    chk("sw_psel_idle", bus.pselx, 0);
    chk("sw_penable_idle", bus.penable, 0);

    // single read 0x8400_0010 returning 0xDEAD_BEEF
    bus.prdata = 32'hDEAD_BEEF;
    drive(32'h8400_0010, 2'b10, 1'b0, 32'h0);
    #1 chk("rd_ns_idle", ns, 2);
    tick();
    chk("rd_ps_read", ps, 2);
    chk("rd_pselx", bus.pselx, 3'b010);
    chk("rd_pwrite", bus.pwrite, 0);
    chk("rd_paddr", bus.paddr, 32'h8400_0010);
    chk("rd_hrdy0", bus.hreadyout, 0);
    chk("rd_penable0", bus.penable, 0);
    drive(32'h8400_0010, 2'b00, 1'b0, 32'h0);
    tick();
    chk("rd_ps_renable", ps, 5);
    chk("rd_penable1", bus.penable, 1);
    chk("rd_hrdy1", bus.hreadyout, 1);
    chk("rd_hrdata", bus.hrdata, 32'hDEAD_BEEF);
    tick();
    chk("rd_ps_idle", ps, 0);
    chk("rd_hrdy_idle", bus.hreadyout, 1);

    // INCR4 write burst at 0x8800_0000, master holding on hreadyout=0
    drive(32'h8800_0000, 2'b10, 1'b1, 32'h0);
    tick();
    chk("b_ps_wwait", ps, 1);
    drive(32'h8800_0004, 2'b11, 1'b1, 32'h11);
    #1 chk("b_ns_writep", ns, 4);
    tick();
    chk("b_ps_writep0", ps, 4);
    chk("b_pselx", bus.pselx, 3'b100);
    chk("b_paddr0", bus.paddr, 32'h8800_0000);
    chk("b_pwdata0", bus.pwdata, 32'h11);
    chk("b_hrdy_wp0", bus.hreadyout, 0);
    drive(32'h8800_0008, 2'b11, 1'b1, 32'h22);
    tick();
    chk("b_ps_wenp0", ps, 7);
    chk("b_penable0", bus.penable, 1);
    tick();
    chk("b_ps_writep1", ps, 4);
    chk("b_paddr1", bus.paddr, 32'h8800_0004);
    chk("b_pwdata1", bus.pwdata, 32'h22);
    chk("b_penable_wp1", bus.penable, 0);
    drive(32'h8800_000C, 2'b11, 1'b1, 32'h33);
    tick();
    chk("b_ps_wenp1", ps, 7);
    tick();
    chk("b_ps_writep2", ps, 4);
    chk("b_paddr2", bus.paddr, 32'h8800_0008);
    chk("b_pwdata2", bus.pwdata, 32'h33);
    drive(32'h8800_000C, 2'b00, 1'b1, 32'h44);
    tick();
    chk("b_ps_wenp2", ps, 7);
    tick();
    chk("b_ps_write3", ps, 3);
    chk("b_paddr3", bus.paddr, 32'h8800_000C);
    chk("b_pwdata3", bus.pwdata, 32'h44);
    chk("b_pwrite3", bus.pwrite, 1);
    tick();
    chk("b_ps_wenable", ps, 6);
    chk("b_penable3", bus.penable, 1);
    tick();
    chk("b_ps_idle", ps, 0);

    // out-of-map, BUSY, hreadyin low, and map edges
    drive(32'h9000_0000, 2'b10, 1'b1, 32'h0);
    #1 chk("oom_ns", ns, 0);
    tick();
    chk("oom_ps", ps, 0);
    chk("oom_pselx", bus.pselx, 0);
    chk("oom_penable", bus.penable, 0);
    chk("oom_hrdy", bus.hreadyout, 1);
    drive(32'h8000_0000, 2'b01, 1'b1, 32'h0);
    #1 chk("busy_ns", ns, 0);
    tick();
    chk("busy_ps", ps, 0);
    chk("busy_pselx", bus.pselx, 0);
    drive(32'h8000_0000, 2'b10, 1'b0, 32'h0);
    bus.hreadyin = 1'b0;
    #1 chk("nrdy_ns", ns, 0);
    bus.hreadyin = 1'b1;
    drive(32'h8C00_0000, 2'b10, 1'b0, 32'h0);
    #1 chk("edge_hi_ns", ns, 0);
    drive(32'h8BFF_FFFC, 2'b10, 1'b0, 32'h0);
    #1 chk("edge_in_ns", ns, 2);
    tick();
    chk("edge_pselx", bus.pselx, 3'b100);
    chk("edge_paddr", bus.paddr, 32'h8BFF_FFFC);
    drive(32'h8BFF_FFFC, 2'b00, 1'b0, 32'h0);
    tick();
    tick();
    chk("edge_ps_idle", ps, 0);

    // reset asserted while in WENABLE
    drive(32'h8400_0000, 2'b10, 1'b1, 32'h0);
    tick();
    drive(32'h8400_0000, 2'b00, 1'b1, 32'h5555_AAAA);
    tick();
    tick();
    chk("ra_ps_wenable", ps, 6);
    chk("ra_penable1", bus.penable, 1);
    hresetn = 1'b0;
    #1;
    chk("ra_ps", ps, 0);
    chk("ra_pselx", bus.pselx, 0);
    chk("ra_penable", bus.penable, 0);
    chk("ra_hrdy", bus.hreadyout, 1);
    chk("ra_pwdata", bus.pwdata, 0);
    tick();
    hresetn = 1'b1;
    tick();
    chk("ra_ps_after", ps, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
